// File: rtl/stack_arbiter.sv
// Two-port round-robin arbiter sharing one operand stack between the core (A) and host/debug (B).
// Optional A-side lock for atomic multi-op sequences is enabled by defining STACK_ARB_LOCK_EN.
module stack_arbiter #(
  parameter int unsigned WIDTH = 66
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic [1:0]       a_op,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_lock,
  output logic             a_gnt,
  output logic             a_done,
  input  logic             b_req,
  input  logic [1:0]       b_op,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_gnt,
  output logic             b_done,
  output logic [WIDTH-1:0] rsp_tos,
  output logic [1:0]       rsp_status,
  output logic             rsp_err,
  output logic [1:0]       stack_op,
  output logic [WIDTH-1:0] stack_data,
  input  logic [WIDTH-1:0] stack_tos,
  input  logic [1:0]       stack_status
);

  // Encodings shared with the stack instance.
  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] ST_EMPTY = 2'd1;

  typedef enum logic [1:0] {StIdle, StIssue, StSettle} state_t;

  state_t           r_state, w_state_d;
  logic [1:0]       r_op, w_op_d;
  logic [WIDTH-1:0] r_data, w_data_d;
  logic             r_win_b, w_win_b_d;
  logic             r_last_b, w_last_b_d;
  logic             r_a_gnt, w_a_gnt_d;
  logic             r_b_gnt, w_b_gnt_d;
  logic             r_a_done, w_a_done_d;
  logic             r_b_done, w_b_done_d;
  logic [WIDTH-1:0] r_tos, w_tos_d;
  logic [1:0]       r_status, w_status_d;
  logic             r_err, w_err_d;
  logic             w_pick_a, w_pick_b;

`ifdef STACK_ARB_LOCK_EN
  logic             r_lock, w_lock_d;
`else
  logic             w_unused_lock;
  assign w_unused_lock = a_lock;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_op_d     = OP_NONE;
    w_data_d   = r_data;
    w_win_b_d  = r_win_b;
    w_last_b_d = r_last_b;
    w_a_gnt_d  = 1'b0;
    w_b_gnt_d  = 1'b0;
    w_a_done_d = 1'b0;
    w_b_done_d = 1'b0;
    w_tos_d    = r_tos;
    w_status_d = r_status;
    w_err_d    = r_err;
`ifdef STACK_ARB_LOCK_EN
    w_lock_d   = r_lock;
`endif

    // A wins when alone or when B was served last.
    w_pick_a = a_req & (~b_req | r_last_b);
    w_pick_b = b_req & ~w_pick_a;
`ifdef STACK_ARB_LOCK_EN
    if (r_lock && a_lock) begin
      w_pick_a = a_req;
      w_pick_b = 1'b0;
    end
`endif

    unique case (r_state)
      StIdle: begin
`ifdef STACK_ARB_LOCK_EN
        if (!a_lock) w_lock_d = 1'b0;
`endif
        if (w_pick_a || w_pick_b) begin
          w_state_d = StIssue;
          w_op_d    = w_pick_b ? b_op : a_op;
          w_data_d  = w_pick_b ? b_data : a_data;
          w_win_b_d = w_pick_b;
          w_a_gnt_d = w_pick_a;
          w_b_gnt_d = w_pick_b;
        end
      end
      StIssue: begin
        w_state_d  = StSettle;
        w_last_b_d = r_win_b;
      end
      StSettle: begin
        w_state_d  = StIdle;
        w_tos_d    = stack_tos;
        w_status_d = stack_status;
        w_err_d    = (stack_status > ST_EMPTY);
        w_a_done_d = ~r_win_b;
        w_b_done_d = r_win_b;
`ifdef STACK_ARB_LOCK_EN
        if (!r_win_b && a_lock) w_lock_d = 1'b1;
`endif
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_op     <= OP_NONE;
      r_data   <= '0;
      r_win_b  <= 1'b0;
      r_last_b <= 1'b1;
      r_a_gnt  <= 1'b0;
      r_b_gnt  <= 1'b0;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      r_tos    <= '0;
      r_status <= 2'd0;
      r_err    <= 1'b0;
`ifdef STACK_ARB_LOCK_EN
      r_lock   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_d;
      r_op     <= w_op_d;
      r_data   <= w_data_d;
      r_win_b  <= w_win_b_d;
      r_last_b <= w_last_b_d;
      r_a_gnt  <= w_a_gnt_d;
      r_b_gnt  <= w_b_gnt_d;
      r_a_done <= w_a_done_d;
      r_b_done <= w_b_done_d;
      r_tos    <= w_tos_d;
      r_status <= w_status_d;
      r_err    <= w_err_d;
`ifdef STACK_ARB_LOCK_EN
      r_lock   <= w_lock_d;
`endif
    end
  end

  assign stack_op   = r_op;
  assign stack_data = r_data;
  assign a_gnt      = r_a_gnt;
  assign b_gnt      = r_b_gnt;
  assign a_done     = r_a_done;
  assign b_done     = r_b_done;
  assign rsp_tos    = r_tos;
  assign rsp_status = r_status;
  assign rsp_err    = r_err;

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares the single operand stack instance between two requesters.
  - Port A: CPU core.
  - Port B: host/debug port (peek/poke of the operand stack while the core is halted or trapped).
- Sequences each request as one stack operation, then returns the resulting TOS and status to the winning requester.
- Fair round-robin between A and B; optional lock gives A atomic multi-op sequences such as select's pop/pop/replace.

Parameters:
- WIDTH, 66, stack word width: 2-bit type tag plus 64-bit value; must match the stack instance.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- a_req  in  1  A requests an operation
- a_op  in  2  A stack op (`NONE/`PUSH/`POP/`REPLACE from stack.vh)
- a_data  in  WIDTH  A push/replace data
- a_lock  in  1  A holds ownership after its current op (only with STACK_ARB_LOCK_EN)
- a_gnt  out  1  one-cycle pulse: A's op issued
- a_done  out  1  one-cycle pulse: A's response valid
- b_req, b_op, b_data  in  1/2/WIDTH  same meanings as the A inputs, for B
- b_gnt, b_done  out  1/1  same meanings as the A outputs, for B
- rsp_tos  out  WIDTH  stack TOS after the granted op
- rsp_status  out  2  stack status after the granted op
- rsp_err  out  1  rsp_status > `EMPTY (overflow/underflow)
- stack_op  out  2  to stack op
- stack_data  out  WIDTH  to stack data
- stack_tos  in  WIDTH  from stack tos
- stack_status  in  2  from stack status

Behaviour:
- Reset values, all outputs registered:
  - stack_op=`NONE, stack_data=0.
  - all gnt/done=0, rsp_*=0.
  - state=IDLE, last=B (so A wins the first tie), lock_owner=none.
- FSM IDLE -> ISSUE -> SETTLE -> IDLE. All transitions are unconditional except the one out of IDLE.
- IDLE (cycle N):
  - If any req is high, pick a winner.
  - Capture the winner's op/data.
  - Set next state ISSUE.
  - No req: stay IDLE, stack_op=`NONE.
- ISSUE (N+1):
  - stack_op/stack_data drive the captured op for exactly this one cycle.
  - Winner's gnt pulses high.
  - last is updated to the winner.
  - The stack executes at the end of N+1.
- SETTLE (N+2):
  - stack_op=`NONE.
  - Sample stack_tos/stack_status into rsp_tos/rsp_status/rsp_err.
  - Winner's done pulses in N+3.
  - Return to IDLE.
- Latency and throughput:
  - req at N -> gnt at N+1 -> done at N+3 with rsp_* valid and held until the next done.
  - A new request is granted in IDLE at N+3, with gnt at N+4.
  - Peak throughput is one op per 3 cycles.
- Arbitration:
  - Only one req high: it wins.
  - Both high: the requester that is not `last` wins.
  - The loser keeps req high and is granted on the next IDLE. A requester is never starved for more than one op, except under lock.
- Request rules:
  - req, op and data must stay stable until gnt.
  - req sampled low in IDLE means no request.
  - A requester that drops req before it is granted has no side effects.
- Op `NONE is a peek: the stack is unchanged, and done returns the current TOS/status.
- Errors:
  - rsp_err is reported, not blocked. The arbiter still completes the op.
  - The requester decides whether to trap (core: trap on rsp_err).
- Only one gnt and at most one done is asserted per cycle. gnt and done never go to different requesters within one transaction.
- Reset mid-transaction: abort to IDLE at the next edge.
  - No done is issued.
  - stack_op=`NONE.
  - The stack's own reset clears its contents.
- Ops are never queued beyond the single captured op.

Optional Feature:
- Macro: STACK_ARB_LOCK_EN.
- Defined:
  - If A was the winner and a_lock=1 when sampled in SETTLE, lock_owner=A.
  - While lock_owner=A, IDLE grants only A; B waits even if b_req=1.
  - The lock releases when a_lock=0 is sampled in IDLE, or on reset. Round-robin then resumes with last=A, so B wins the next tie.
- Undefined: a_lock is ignored and arbitration is pure round-robin.

Test Plan:
- Reset, then a_req with `PUSH {i32, 32'h0, 32'd7} -> a_gnt at +1, a_done at +3, rsp_tos={2'b00,64'd7}, rsp_err=0.
- a_req and b_req both high at the same cycle, both `PUSH (A=5, B=9) -> A is granted first, then B. A's done carries 5; B's done carries 9.
- B `NONE peek after A pushes 3 -> stack unchanged, b_done with rsp_tos=3. A subsequent A `POP returns status `EMPTY.
- `POP on an empty stack -> done with rsp_status > `EMPTY and rsp_err=1. The FSM returns to IDLE and the next request is served normally.
- Push 8 values to a depth-8 stack, then a 9th push -> the 9th done has rsp_err=1.
- Reset asserted in the ISSUE cycle -> no done is issued, stack_op=`NONE next cycle, and a fresh a_req is granted after reset drops. With STACK_ARB_LOCK_EN: a_lock=1 across three A ops while b_req is held -> B is granted only after a_lock falls.
